// File: rtl/systolic_drain.sv
// Drains skewed systolic-array rows: deskews lanes, quantizes each lane
// (shift, optional ReLU, saturate) and buffers whole vectors in an FWFT FIFO.
module systolic_drain #(
   parameter int ARRAY_M      = 8,
   parameter int PE_OUT_WIDTH = 19,
   parameter int OUT_WIDTH    = 8,
   parameter int SHIFT_WIDTH  = $clog2(PE_OUT_WIDTH),
   parameter int FIFO_DEPTH   = 32
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [ARRAY_M*PE_OUT_WIDTH-1:0]   sys_in,
   input  logic                              in_valid,
   input  logic                              in_last,
   input  logic [SHIFT_WIDTH-1:0]            shift,
   input  logic                              relu_en,
   output logic [ARRAY_M*OUT_WIDTH-1:0]      out_data,
   output logic                              out_last,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic                              stall_req,
   output logic                              overflow,
   input  logic                              clr_err
);

   localparam int PTR_W    = $clog2(FIFO_DEPTH) + 1;
   localparam int AW       = PTR_W - 1;
   localparam int ENTRY_W  = ARRAY_M*OUT_WIDTH + 1;
   localparam int STALL_TH = FIFO_DEPTH - (ARRAY_M + 1);

   localparam logic signed [PE_OUT_WIDTH-1:0] Q_MAX = PE_OUT_WIDTH'((1 << (OUT_WIDTH-1)) - 1);
   localparam logic signed [PE_OUT_WIDTH-1:0] Q_MIN = ~Q_MAX;
   localparam logic [OUT_WIDTH-1:0] SAT_HI = {1'b0, {(OUT_WIDTH-1){1'b1}}};
   localparam logic [OUT_WIDTH-1:0] SAT_LO = {1'b1, {(OUT_WIDTH-1){1'b0}}};

   function automatic logic signed [PE_OUT_WIDTH-1:0] shift_relu(
      input logic signed [PE_OUT_WIDTH-1:0] x,
      input logic [SHIFT_WIDTH-1:0]         sh,
      input logic                           relu
   );
      logic signed [PE_OUT_WIDTH-1:0] v;
      v = x >>> sh;
      if (relu && (v < 0)) v = '0;
      return v;
   endfunction

   function automatic logic [OUT_WIDTH-1:0] saturate(input logic signed [PE_OUT_WIDTH-1:0] v);
      if (v > Q_MAX)      return SAT_HI;
      else if (v < Q_MIN) return SAT_LO;
      else                return v[OUT_WIDTH-1:0];
   endfunction

   // Stage p0..p(M-1): control shift register travelling with the skewed data
   logic                   vld_p   [ARRAY_M];
   logic                   last_p  [ARRAY_M];
   logic                   relu_p  [ARRAY_M];
   logic [SHIFT_WIDTH-1:0] shift_p [ARRAY_M];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < ARRAY_M; k++) begin
            vld_p[k]   <= 1'b0;
            last_p[k]  <= 1'b0;
            relu_p[k]  <= 1'b0;
            shift_p[k] <= '0;
         end
      end else begin
         vld_p[0]   <= in_valid;
         last_p[0]  <= in_last;
         relu_p[0]  <= relu_en;
         shift_p[0] <= shift;
         for (int k = 1; k < ARRAY_M; k++) begin
            vld_p[k]   <= vld_p[k-1];
            last_p[k]  <= last_p[k-1];
            relu_p[k]  <= relu_p[k-1];
            shift_p[k] <= shift_p[k-1];
         end
      end
   end

   // Lane m arrives m cycles after in_valid, so its qualifier is the control pipe tap m-1
   logic lane_vld [ARRAY_M];
   always_comb begin
      lane_vld[0] = in_valid;
      for (int m = 1; m < ARRAY_M; m++) lane_vld[m] = vld_p[m-1];
   end

   logic signed [PE_OUT_WIDTH-1:0] aligned [ARRAY_M];

   for (genvar m = 0; m < ARRAY_M; m++) begin : g_lane
      localparam int D = ARRAY_M - m;
      logic signed [PE_OUT_WIDTH-1:0] skew_p [D];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int k = 0; k < D; k++) skew_p[k] <= '0;
         end else begin
            skew_p[0] <= lane_vld[m] ? $signed(sys_in[m*PE_OUT_WIDTH +: PE_OUT_WIDTH]) : '0;
            for (int k = 1; k < D; k++) skew_p[k] <= skew_p[k-1];
         end
      end

      assign aligned[m] = skew_p[D-1];
   end

   logic [ARRAY_M*OUT_WIDTH-1:0] q_vec;
   always_comb begin
      q_vec = '0;
      for (int m = 0; m < ARRAY_M; m++)
         q_vec[m*OUT_WIDTH +: OUT_WIDTH] =
            saturate(shift_relu(aligned[m], shift_p[ARRAY_M-1], relu_p[ARRAY_M-1]));
   end

   // Quantize stage: the FIFO entry itself is the quantize register, so the
   // vector is visible at the head one edge after alignment.
   logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr, wr_next, rd_next, occ_next;
   logic               empty, full, push, pop, wr_en, drop;
   logic [ENTRY_W-1:0] head;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign push     = vld_p[ARRAY_M-1];
   assign pop      = out_valid && out_ready;
   assign wr_en    = push && (!full || pop);
   assign drop     = push && full && !pop;
   assign wr_next  = wr_ptr + PTR_W'(wr_en);
   assign rd_next  = rd_ptr + PTR_W'(pop);
   assign occ_next = wr_next - rd_next;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= {last_p[ARRAY_M-1], q_vec};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         stall_req <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         wr_ptr    <= wr_next;
         rd_ptr    <= rd_next;
         stall_req <= (occ_next >= PTR_W'(STALL_TH));
         if (drop)         overflow <= 1'b1;
         else if (clr_err) overflow <= 1'b0;
      end
   end

   // Head is masked while empty so stale memory never shows after reset
   assign head      = mem[rd_ptr[AW-1:0]];
   assign out_valid = !empty;
   assign out_data  = out_valid ? head[ENTRY_W-2:0] : '0;
   assign out_last  = out_valid && head[ENTRY_W-1];

endmodule
